fetch_unit: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the 16-bit five-stage processor. It is the producer side of the decode-stage interface.
- Maintains the PC and requests 16-bit words from instruction memory over a req/ack handshake. Assembles one- or two-word instructions.
- Presents opcode/src/dst/shiftamount (plus immediate and PC) to decode with a valid flag. Honours stall, flush and branch redirect.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and IF/ID signal bundle for fetch_unit
// Purpose: groups the instruction-memory req/ack bus and the decode-facing IF/ID outputs.
// Ports (master = fetch_unit side):
//   imem_req/imem_addr out, imem_rdata/imem_ack in   instruction-memory read handshake
//   valid/opcode/src/dst/shiftamount/imm/pc_out out  IF/ID register contents for decode
interface fetch_unit_if #(
    parameter int W  = 16,
    parameter int AW = 16
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [W-1:0]  imem_rdata;
    logic          imem_ack;

    logic          valid;
    logic [5:0]    opcode;
    logic [2:0]    src;
    logic [2:0]    dst;
    logic [3:0]    shiftamount;
    logic [W-1:0]  imm;
    logic [AW-1:0] pc_out;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output valid, opcode, src, dst, shiftamount, imm, pc_out
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  valid, opcode, src, dst, shiftamount, imm, pc_out
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID pipeline register
// Purpose: keeps the PC, reads 16-bit words from instruction memory, assembles one- or
// two-word instructions (opcode bit 5 set means an immediate word follows) and presents
// them to decode through the IF/ID register, honouring stall, flush and branch redirect.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active low
//   stall          in   hold IF/ID contents while valid
//   flush          in   squash the instruction currently in IF/ID
//   branch_taken   in   redirect fetch to branch_target, discarding all in-flight work
//   branch_target  in   redirect address
//   bus            master modport: imem req/addr/rdata/ack and IF/ID outputs
module fetch_unit #(
    parameter int            W        = 16,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {S_FETCH, S_FETCH_IMM, S_PEND} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    // first word of a two-word instruction and its address
    logic [W-1:0]  first_q, first_d;
    logic [AW-1:0] first_pc_q, first_pc_d;
    // one-deep buffer for a completed instruction blocked by a stalled IF/ID
    logic [W-1:0]  pend_instr_q, pend_instr_d;
    logic [W-1:0]  pend_imm_q, pend_imm_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;
    // IF/ID register
    logic          valid_q, valid_d;
    logic [W-1:0]  instr_q, instr_d;
    logic [W-1:0]  imm_q, imm_d;
    logic [AW-1:0] pc_out_q, pc_out_d;

    logic          ack_ok;
    logic          ifid_free;
    logic          done;
    logic [W-1:0]  done_instr, done_imm;
    logic [AW-1:0] done_pc;

    // Held low during reset so an ack arriving then is ignored.
    assign bus.imem_req  = rst && (state_q != S_PEND);
    assign bus.imem_addr = pc_q;
    assign ack_ok        = bus.imem_req && bus.imem_ack;
    // A stall only blocks loading when there is a live instruction to protect.
    assign ifid_free     = !valid_q || !stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        first_d      = first_q;
        first_pc_d   = first_pc_q;
        pend_instr_d = pend_instr_q;
        pend_imm_d   = pend_imm_q;
        pend_pc_d    = pend_pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        imm_d        = imm_q;
        pc_out_d     = pc_out_q;
        done         = 1'b0;
        done_instr   = '0;
        done_imm     = '0;
        done_pc      = '0;

        case (state_q)
            S_FETCH: begin
                if (ack_ok) begin
                    pc_d = pc_q + AW'(1);
                    if (bus.imem_rdata[15]) begin
                        first_d    = bus.imem_rdata;
                        first_pc_d = pc_q;
                        state_d    = S_FETCH_IMM;
                    end else begin
                        done       = 1'b1;
                        done_instr = bus.imem_rdata;
                        done_pc    = pc_q;
                    end
                end
            end
            S_FETCH_IMM: begin
                if (ack_ok) begin
                    pc_d       = pc_q + AW'(1);
                    done       = 1'b1;
                    done_instr = first_q;
                    done_imm   = bus.imem_rdata;
                    done_pc    = first_pc_q;
                end
            end
            S_PEND: begin
                done       = 1'b1;
                done_instr = pend_instr_q;
                done_imm   = pend_imm_q;
                done_pc    = pend_pc_q;
            end
            default: state_d = S_FETCH;
        endcase

        if (done) begin
            if (ifid_free) begin
                state_d = S_FETCH;
            end else begin
                pend_instr_d = done_instr;
                pend_imm_d   = done_imm;
                pend_pc_d    = done_pc;
                state_d      = S_PEND;
            end
        end

        // IF/ID: a completing instruction beats flush (flush targets the old one);
        // with no stall the old instruction has been consumed and leaves as a bubble.
        if (branch_taken || (!(done && ifid_free) && (flush || !stall))) begin
            valid_d  = 1'b0;
            instr_d  = '0;
            imm_d    = '0;
            pc_out_d = '0;
        end else if (done && ifid_free) begin
            valid_d  = 1'b1;
            instr_d  = done_instr;
            imm_d    = done_imm;
            pc_out_d = done_pc;
        end

        // Redirect drops partial instruction, pending buffer and any same-cycle ack.
        if (branch_taken) begin
            state_d = S_FETCH;
            pc_d    = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            first_q      <= '0;
            first_pc_q   <= '0;
            pend_instr_q <= '0;
            pend_imm_q   <= '0;
            pend_pc_q    <= '0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            imm_q        <= '0;
            pc_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            first_q      <= first_d;
            first_pc_q   <= first_pc_d;
            pend_instr_q <= pend_instr_d;
            pend_imm_q   <= pend_imm_d;
            pend_pc_q    <= pend_pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            imm_q        <= imm_d;
            pc_out_q     <= pc_out_d;
        end
    end

    assign bus.valid       = valid_q;
    assign bus.opcode      = instr_q[15:10];
    assign bus.src         = instr_q[9:7];
    assign bus.dst         = instr_q[6:4];
    assign bus.shiftamount = instr_q[3:0];
    assign bus.imm         = imm_q;
    assign bus.pc_out      = pc_out_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;
    localparam int W  = 16;
    localparam int AW = 16;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_target;

    logic [15:0] mem [0:65535];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          wait_min = 0;
    int          wait_max = 0;
    bit          mon_en = 1'b0;
    int          mon_cnt = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.W(W), .AW(AW)) bus ();

    fetch_unit #(.W(W), .AW(AW), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .bus          (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Random program image; pct2 percent of words are two-word opcodes.
    task automatic fill_mem(input int pct2);
        logic [15:0] w;
        for (int i = 0; i < 65536; i++) begin
            w     = 16'($urandom);
            w[15] = ($urandom_range(99) < pct2);
            mem[i] = w;
        end
    endtask

    // Program-order instruction stream starting at a given address.
    task automatic build_exp(input logic [15:0] start);
        logic [15:0] p;
        exp_t        e;
        exp_q.delete();
        p = start;
        for (int n = 0; n < 400; n++) begin
            e.instr = mem[p];
            e.pc    = p;
            if (mem[p][15]) begin
                e.imm = mem[16'(p + 16'd1)];
                p     = 16'(p + 16'd2);
            end else begin
                e.imm = 16'h0000;
                p     = 16'(p + 16'd1);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset;
        mon_en = 1'b0;
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0000;
        wait_min = 0; wait_max = 0;
        tick;
        tick;
        @(negedge clk);
        chk("rst_valid", bus.valid, 0);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_fields", {bus.opcode, bus.src, bus.dst, bus.shiftamount, bus.imm, bus.pc_out}, 0);
    endtask

    // Instruction memory responder: ack after a random number of wait cycles.
    initial begin : mem_model
        logic        waiting;
        int          wcnt;
        logic [15:0] last_addr;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        waiting = 1'b0;
        wcnt = 0;
        last_addr = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (!bus.imem_req) begin
                bus.imem_ack = 1'b0;
                waiting = 1'b0;
            end else begin
                if (!waiting || bus.imem_addr != last_addr) begin
                    waiting = 1'b1;
                    wcnt = $urandom_range(wait_max, wait_min);
                    last_addr = bus.imem_addr;
                end
                if (wcnt == 0) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = mem[bus.imem_addr];
                    waiting = 1'b0;
                end else begin
                    bus.imem_ack = 1'b0;
                    bus.imem_rdata = 16'($urandom);
                    wcnt--;
                end
            end
        end
    end

    // Monitor: an instruction leaves IF/ID when decode takes it (no stall) or it is flushed;
    // a branch squashes everything and restarts the stream at the target.
    initial begin : monitor
        logic        hold_prev;
        logic        br_prev;
        logic [48:0] snap;
        logic [48:0] cur;
        exp_t        e;
        hold_prev = 1'b0;
        br_prev = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                hold_prev = 1'b0;
                br_prev = 1'b0;
            end else begin
                cur = {bus.valid, bus.opcode, bus.src, bus.dst, bus.shiftamount, bus.imm, bus.pc_out};
                if (hold_prev) chk("stall_hold", cur, snap);
                if (br_prev) chk("branch_clears_valid", bus.valid, 0);
                if (branch_taken) begin
                    build_exp(branch_target);
                end else if (bus.valid && (!stall || flush)) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underflow: got instruction pc %0h expected none", bus.pc_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_instr", cur[47:0], {e.instr, e.imm, e.pc});
                        mon_cnt++;
                    end
                end
                hold_prev = bus.valid && stall && !flush && !branch_taken;
                br_prev = branch_taken;
                snap = cur;
            end
        end
    end

    initial begin : main
        int cyc;

        // basic single-word stream, zero-wait memory
        do_reset;
        fill_mem(0);
        mem[0] = 16'h0A5B; mem[1] = 16'h1234; mem[2] = 16'h0C00;
        build_exp(16'h0000);
        tick; rst = 1'b1; mon_en = 1'b1;
        @(negedge clk);
        chk("a_req", bus.imem_req, 1);
        chk("a_addr", bus.imem_addr, 16'h0000);
        chk("a_valid_early", bus.valid, 0);
        tick; @(negedge clk);
        chk("a_valid", bus.valid, 1);
        chk("a_opcode", bus.opcode, 6'h02);
        chk("a_src", bus.src, 3'd4);
        chk("a_dst", bus.dst, 3'd5);
        chk("a_shamt", bus.shiftamount, 4'hB);
        chk("a_pc0", bus.pc_out, 16'h0000);
        tick; @(negedge clk);
        chk("a_pc1", bus.pc_out, 16'h0001);
        repeat (6) tick;

        // two-word instruction
        do_reset;
        fill_mem(30);
        mem[0] = 16'h8000; mem[1] = 16'hBEEF; mem[2][15] = 1'b0;
        build_exp(16'h0000);
        tick; rst = 1'b1; mon_en = 1'b1;
        tick; @(negedge clk);
        chk("b_valid_mid", bus.valid, 0);
        tick; @(negedge clk);
        chk("b_valid", bus.valid, 1);
        chk("b_opcode", bus.opcode, 6'h20);
        chk("b_imm", bus.imm, 16'hBEEF);
        chk("b_pc", bus.pc_out, 16'h0000);
        tick; @(negedge clk);
        chk("b_next_pc", bus.pc_out, 16'h0002);
        chk("b_next_imm", bus.imm, 16'h0000);
        repeat (8) tick;

        // three-cycle stall with a live instruction
        do_reset;
        fill_mem(0);
        build_exp(16'h0000);
        tick; rst = 1'b1; mon_en = 1'b1;
        tick; tick; stall = 1'b1;
        @(negedge clk);
        chk("c_valid", bus.valid, 1);
        tick; @(negedge clk);
        chk("c_req_pend1", bus.imem_req, 0);
        tick; @(negedge clk);
        chk("c_req_pend2", bus.imem_req, 0);
        tick; stall = 1'b0;
        repeat (10) tick;

        // branch while collecting the immediate word
        do_reset;
        fill_mem(30);
        mem[0] = 16'h8001; mem[1] = 16'h1111; mem[16'h0040][15] = 1'b0;
        build_exp(16'h0000);
        tick; rst = 1'b1; mon_en = 1'b1;
        tick; branch_taken = 1'b1; branch_target = 16'h0040;
        @(negedge clk);
        chk("d_req_imm", bus.imem_req, 1);
        chk("d_addr_imm", bus.imem_addr, 16'h0001);
        tick; branch_taken = 1'b0;
        @(negedge clk);
        chk("d_valid", bus.valid, 0);
        chk("d_addr", bus.imem_addr, 16'h0040);
        chk("d_req", bus.imem_req, 1);
        tick; @(negedge clk);
        chk("d_first_pc", bus.pc_out, 16'h0040);
        repeat (10) tick;

        // flush together with stall
        do_reset;
        fill_mem(0);
        build_exp(16'h0000);
        tick; rst = 1'b1; mon_en = 1'b1;
        tick; tick; tick; flush = 1'b1; stall = 1'b1;
        @(negedge clk);
        chk("e_valid_pre", bus.valid, 1);
        tick; flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("e_valid", bus.valid, 0);
        chk("e_addr", bus.imem_addr, 16'h0004);
        chk("e_req", bus.imem_req, 0);
        tick; @(negedge clk);
        chk("e_resume_valid", bus.valid, 1);
        chk("e_resume_pc", bus.pc_out, 16'h0003);
        repeat (10) tick;

        // PC wrap with three wait cycles
        do_reset;
        fill_mem(30);
        mem[16'hFFFF][15] = 1'b0;
        wait_min = 3; wait_max = 3;
        build_exp(16'h0000);
        tick; rst = 1'b1; branch_taken = 1'b1; branch_target = 16'hFFFF; mon_en = 1'b1;
        tick; branch_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("f_addr_hold", {bus.imem_req, bus.imem_addr}, {1'b1, 16'hFFFF});
            tick;
        end
        @(negedge clk);
        chk("f_addr_wrap", bus.imem_addr, 16'h0000);
        chk("f_valid", bus.valid, 1);
        chk("f_pc", bus.pc_out, 16'hFFFF);
        wait_min = 0; wait_max = 2;
        repeat (20) tick;

        // randomized stall/flush/branch/wait traffic
        do_reset;
        fill_mem(30);
        wait_min = 0; wait_max = 2;
        build_exp(16'h0000);
        tick; rst = 1'b1; mon_en = 1'b1; mon_cnt = 0;
        cyc = 0;
        while (cyc < 4000 && mon_cnt < 200) begin
            stall = ($urandom_range(99) < 25);
            flush = ($urandom_range(99) < 8);
            branch_taken = ($urandom_range(99) < 3);
            branch_target = 16'($urandom);
            tick;
            cyc++;
        end
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        chk("rand_progress", (mon_cnt >= 200), 1);
        mon_en = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
